// File: rtl/fade_sched_pack.sv
// Shared types and timing constants for the fade scheduler and its output FIFO.
package fade_sched_pack;
  localparam int N_DEF      = 32;
  localparam int M_DEF      = 8;
  localparam int MIN_PERIOD = M_DEF * N_DEF + 16;
  localparam int WDOG       = 2 * M_DEF * N_DEF + 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] imag;
    logic [15:0] re;
    logic [4:0]  chan;
    logic        last;
  } fifo_word_t;

  localparam int WORD_W = $bits(fifo_word_t);
endpackage

// File: rtl/fade_fifo.sv
// First-word fall-through FIFO; read data reads as zero while empty.
module fade_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] free_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             full;

  assign count      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (count == (AW+1)'(DEPTH));
  assign free_count = (AW+1)'(DEPTH) - count;
  assign rd_data    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/fade_scheduler.sv
// Paces the Jakes fader with periodic start pulses and buffers each frame of
// per-channel results into a backpressured stream.
module fade_scheduler
  import fade_sched_pack::*;
#(
  parameter int N          = N_DEF,
  parameter int M          = M_DEF,
  parameter int TW         = 25,
  parameter int FIFO_DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [15:0]   period,
  input  logic          load_t,
  input  logic [TW-1:0] t_init,
  output logic          fade_start,
  output logic [TW-1:0] fade_t_index,
  input  logic          fade_dv,
  input  logic [4:0]    fade_chan,
  input  logic [15:0]   fade_imag,
  input  logic [15:0]   fade_real,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [31:0]   m_tdata,
  output logic [4:0]    m_tuser,
  output logic          m_tlast,
  output logic          busy,
  output logic          err_overrun,
  output logic          err_drop,
  output logic          err_timeout,
  input  logic          err_clear,
  output logic [15:0]   frame_count,
  output state_t        dbg_state
);
  // Package constants are for the default geometry; rescale for other M/N.
  localparam int MINP   = MIN_PERIOD + (M * N - M_DEF * N_DEF);
  localparam int WDG    = WDOG + 2 * (M * N - M_DEF * N_DEF);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int DVW    = $clog2(N) + 1;
  localparam int WDW    = $clog2(WDG);
  localparam logic [15:0] MINP16 = 16'(MINP);

  state_t          state;
  logic [15:0]     timer;
  logic [15:0]     eff;
  logic            tick;
  logic [TW-1:0]   t;
  logic [DVW-1:0]  dv_cnt;
  logic [WDW-1:0]  wd_cnt;
  logic            in_valid_q;
  fifo_word_t      in_word_q;
  fifo_word_t      rd_word;
  logic            fifo_empty;
  logic [CW-1:0]   free_count;
  logic            space_ok;

  assign eff  = (period < MINP16) ? MINP16 : period;
  assign tick = enable && (timer >= eff - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               timer <= '0;
    else if (!enable || tick)   timer <= '0;
    else                        timer <= timer + 16'd1;
  end

  // Time keeps advancing on skipped ticks so fade time tracks wall time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     t <= '0;
    else if (load_t)  t <= t_init;
    else if (tick)    t <= t + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_valid_q <= 1'b0;
      in_word_q  <= '0;
    end else begin
      in_valid_q <= fade_dv && (state == RUN);
      in_word_q  <= '{imag: fade_imag, re: fade_real, chan: fade_chan,
                      last: (fade_chan == 5'd0)};
    end
  end

  // A word still in the input register is not yet counted by the FIFO.
  assign space_ok = (free_count - CW'(in_valid_q)) >= CW'(N);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      fade_start   <= 1'b0;
      fade_t_index <= '0;
      busy         <= 1'b0;
      dv_cnt       <= '0;
      wd_cnt       <= '0;
      frame_count  <= '0;
      err_overrun  <= 1'b0;
      err_drop     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      fade_start <= 1'b0;
      if (err_clear) begin
        err_overrun <= 1'b0;
        err_drop    <= 1'b0;
        err_timeout <= 1'b0;
      end
      case (state)
        IDLE: if (enable) state <= WAIT;
        WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tick) begin
            if (space_ok) begin
              fade_start   <= 1'b1;
              fade_t_index <= t;
              dv_cnt       <= '0;
              wd_cnt       <= '0;
              state        <= RUN;
            end else begin
              err_drop <= 1'b1;
            end
          end
        end
        RUN: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (fade_start) busy <= 1'b1;
          if (tick) err_overrun <= 1'b1;
          if (fade_dv && (dv_cnt == DVW'(N - 1))) begin
            frame_count <= frame_count + 16'd1;
            busy        <= 1'b0;
            state       <= enable ? WAIT : IDLE;
          end else begin
            if (fade_dv) dv_cnt <= dv_cnt + 1'b1;
            if (wd_cnt == WDW'(WDG - 1)) begin
              err_timeout <= 1'b1;
              busy        <= 1'b0;
              state       <= WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stream handshake: a word moves on any cycle with m_tvalid && m_tready;
  // while m_tvalid is high and m_tready low, m_* hold their value.
  fade_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (in_valid_q),
    .wr_data    (in_word_q),
    .rd_en      (m_tvalid && m_tready),
    .rd_data    (rd_word),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  assign m_tvalid  = !fifo_empty;
  assign m_tdata   = {rd_word.imag, rd_word.re};
  assign m_tuser   = rd_word.chan;
  assign m_tlast   = rd_word.last;
  assign dbg_state = state;
endmodule

// File: tb/tb_fade_scheduler.sv
// Randomized bench for fade_scheduler: fader stand-in, start-time model and
// an output-word scoreboard.
module tb_fade_scheduler;
  import fade_sched_pack::*;

  localparam int N      = 32;
  localparam int M      = 8;
  localparam int TW     = 25;
  localparam int MIN_P  = M * N + 16;
  localparam int WDOG_C = 2 * M * N + 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   period = 16'd300;
  logic          load_t = 1'b0;
  logic [TW-1:0] t_init = '0;
  logic          fade_start;
  logic [TW-1:0] fade_t_index;
  logic          fade_dv = 1'b0;
  logic [4:0]    fade_chan = '0;
  logic [15:0]   fade_imag = '0;
  logic [15:0]   fade_real = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [31:0]   m_tdata;
  logic [4:0]    m_tuser;
  logic          m_tlast;
  logic          busy;
  logic          err_overrun, err_drop, err_timeout;
  logic          err_clear = 1'b0;
  logic [15:0]   frame_count;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [37:0] exp_q[$];

  int            seg_e = 0, seg_eff = MIN_P, starts_seen = 0, last_start = 0;
  int            timeouts_seen = 0, exp_frames = 0;
  logic [TW-1:0] seg_t0 = '0, t_model = '0;
  logic          hold_ready = 1'b0, stall_once = 1'b0;
  int            stray_at = -1;
  logic          fm_active = 1'b0;

  fade_scheduler dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
    .load_t(load_t), .t_init(t_init), .fade_start(fade_start),
    .fade_t_index(fade_t_index), .fade_dv(fade_dv), .fade_chan(fade_chan),
    .fade_imag(fade_imag), .fade_real(fade_real), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .busy(busy), .err_overrun(err_overrun),
    .err_drop(err_drop), .err_timeout(err_timeout), .err_clear(err_clear),
    .frame_count(frame_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // fader stand-in: chan N-1..0 with random gaps, optional stall after 10 words
  initial begin
    int fm_chan, fm_sent, fm_wait;
    logic fm_stall;
    logic [15:0] im, re;
    fm_chan = 0; fm_sent = 0; fm_wait = 0; fm_stall = 1'b0;
    forever begin
      @(posedge clk); #1;
      fade_dv = 1'b0;
      if (!reset_n) begin
        fm_active = 1'b0;
        stray_at  = -1;
      end else if (cyc == stray_at) begin
        fade_dv   = 1'b1;
        fade_chan = 5'($urandom);
        fade_imag = 16'($urandom);
        fade_real = 16'($urandom);
        stray_at  = -1;
      end else if (fade_start) begin
        fm_active  = 1'b1;
        fm_chan    = N - 1;
        fm_sent    = 0;
        fm_wait    = $urandom_range(1, 4);
        fm_stall   = stall_once;
        stall_once = 1'b0;
        if (fm_stall) stray_at = cyc + 620;
      end else if (fm_active) begin
        if (fm_wait > 0) begin
          fm_wait--;
        end else if (fm_stall && fm_sent == 10) begin
          fm_active = 1'b0;
        end else begin
          im = 16'($urandom);
          re = 16'($urandom);
          fade_dv   = 1'b1;
          fade_chan = fm_chan[4:0];
          fade_imag = im;
          fade_real = re;
          exp_q.push_back({im, re, fm_chan[4:0], (fm_chan == 0)});
          fm_sent++;
          fm_chan--;
          fm_wait = $urandom_range(3, 7);
          if (fm_sent == N) fm_active = 1'b0;
        end
      end
    end
  end

  // consumer ready
  initial forever begin
    @(posedge clk); #1;
    m_tready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // start monitor: starts land on multiples of eff_period after enable rises
  initial forever begin
    int d;
    logic [TW-1:0] ei;
    @(negedge clk);
    if (reset_n && fade_start) begin
      d = cyc - seg_e;
      starts_seen++;
      last_start = cyc;
      check("start_phase", (d > 0) && (d % seg_eff == 0), 1);
      ei = seg_t0 + TW'(d / seg_eff) - TW'(1);
      check("t_index", fade_t_index, ei);
    end
  end

  // timeout monitor
  initial begin
    logic prev_to;
    prev_to = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && err_timeout && !prev_to) begin
        timeouts_seen++;
        check("timeout_latency", cyc - last_start, WDOG_C);
      end
      prev_to = err_timeout;
    end
  end

  // scoreboard monitor
  initial begin
    logic        have_hold;
    logic [37:0] hold_word, w;
    have_hold = 1'b0;
    hold_word = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        have_hold = 1'b0;
      end else begin
        if (have_hold)
          check("hold_stable", {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, hold_word});
        have_hold = m_tvalid && !m_tready;
        hold_word = {m_tdata, m_tuser, m_tlast};
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected no word", {m_tdata, m_tuser, m_tlast});
          end else begin
            w = exp_q.pop_front();
            check("word", {m_tdata, m_tuser, m_tlast}, w);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || fm_active) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    check("drain_done", n < 3000, 1);
  endtask

  task automatic run_seg(input int per, input int nticks, input int exp_starts);
    @(posedge clk); #1;
    period      = 16'(per);
    seg_eff     = (per < MIN_P) ? MIN_P : per;
    seg_t0      = t_model;
    seg_e       = cyc;
    starts_seen = 0;
    enable      = 1'b1;
    repeat (nticks * seg_eff + 10) @(posedge clk);
    #1;
    enable     = 1'b0;
    hold_ready = 1'b0;
    t_model    = seg_t0 + TW'((cyc - seg_e) / seg_eff);
    drain();
    check("start_count", starts_seen, exp_starts);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fade_start"}, fade_start, 0);
    check({tag, "_t_index"}, fade_t_index, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
    check({tag, "_m_tuser"}, m_tuser, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_errs"}, {err_overrun, err_drop, err_timeout}, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // nominal period
    run_seg(300, 4, 4);
    exp_frames += 4;
    check("fc_nominal", frame_count, exp_frames);
    check("errs_nominal", {err_overrun, err_drop, err_timeout}, 0);

    // period below the minimum is raised to M*N+16
    run_seg(100, 3, 3);
    exp_frames += 3;
    check("fc_minperiod", frame_count, exp_frames);

    // consumer stalled: two frames fill the FIFO, third tick is dropped
    hold_ready = 1'b1;
    run_seg(300, 3, 2);
    exp_frames += 2;
    check("fc_drop", frame_count, exp_frames);
    check("errs_drop", {err_overrun, err_drop, err_timeout}, 3'b010);
    pulse_clear();
    @(negedge clk);
    check("errs_cleared", {err_overrun, err_drop, err_timeout}, 0);

    // fader stalls after 10 words: watchdog, then a normal frame
    stall_once = 1'b1;
    timeouts_seen = 0;
    run_seg(700, 2, 2);
    exp_frames += 1;
    check("fc_timeout", frame_count, exp_frames);
    check("timeouts_seen", timeouts_seen, 1);
    check("errs_timeout", {err_overrun, err_drop, err_timeout}, 3'b001);
    pulse_clear();

    // time index wraps after a load of the all-ones value
    @(posedge clk); #1 load_t = 1'b1; t_init = '1;
    @(posedge clk); #1 load_t = 1'b0;
    t_model = '1;
    run_seg(300, 2, 2);
    exp_frames += 2;
    check("fc_wrap", frame_count, exp_frames);

    // asynchronous reset in the middle of a frame
    @(posedge clk); #1;
    period = 16'd300; seg_eff = 300; seg_t0 = t_model; seg_e = cyc;
    starts_seen = 0; enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fade_start && n < 1000);
    check("reset_seg_start_seen", fade_start, 1);
    check("busy_at_start", busy, 0);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    repeat (100) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    t_model = '0;
    exp_frames = 0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    run_seg(300, 1, 1);
    exp_frames += 1;
    check("fc_after_reset", frame_count, exp_frames);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fade_scheduler.md
# fade_scheduler

Sequences the multi-channel Modified Jakes fader: it generates a periodic update tick and issues the `start` pulse with the current time index. It counts the fader's per-channel results until a full frame is complete and buffers the results into a backpressured stream. It sits between the fader core and the channel-emulator consumers, which cannot accept the fader's unthrottled output directly.

## Interface
- `N`, 32: fader channels per frame.
- `M`, 8: paths per channel; the fader needs M*N cycles per frame.
- `TW`, 25: time-index width.
- `FIFO_DEPTH`, 64: output buffer entries (power of two, ≥ 2*N).
- `clk` input 1: single clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: level; allows new ticks.
- `period` input 16: clock cycles between ticks; effective value is max(period, M*N+16).
- `load_t` input 1: pulse; loads `t_init` into the time counter.
- `t_init` input TW: time-index load value.
- `fade_start` output 1: one-cycle start pulse to the fader.
- `fade_t_index` output TW: time index to the fader.
- `fade_dv` input 1: fader result valid.
- `fade_chan` input 5: fader result channel.
- `fade_imag` input 16: fader result, imaginary part.
- `fade_real` input 16: fader result, real part.
- `m_tvalid` output 1: output stream valid.
- `m_tready` input 1: output stream ready.
- `m_tdata` output 32: {imag, real}.
- `m_tuser` output 5: channel number.
- `m_tlast` output 1: high on the channel-0 word, the last word of a frame.
- `busy` output 1: a frame is in flight.
- `err_overrun` output 1: sticky; a tick arrived while a frame was in flight.
- `err_drop` output 1: sticky; a frame was skipped for lack of FIFO space.
- `err_timeout` output 1: sticky; the watchdog expired.
- `err_clear` input 1: pulse; clears all sticky errors.
- `frame_count` output 16: completed frames, wraps.

## Operation
- Tick timer: counts 0..eff_period-1 while `enable`=1 and pulses `tick` at the wrap. With `enable`=0 the timer is held at 0.
- Time counter `t`: increments by 1 on every tick, including skipped ticks, so fade time stays tied to wall time. Wraps modulo 2^TW. `load_t` has priority over the increment.
- FSM states:
  - IDLE: on reset, or when `enable`=0 with no frame in flight.
  - WAIT: waiting for a tick.
  - RUN: frame in flight.
- Transitions:
  - IDLE→WAIT when `enable`=1.
  - WAIT→IDLE when `enable`=0.
  - WAIT on tick, with free FIFO space ≥ N: assert `fade_start`, set `fade_t_index`=`t` (the pre-increment value), clear the dv counter, go to RUN.
  - WAIT on tick, with free space < N: no start, set `err_drop`, stay in WAIT.
  - RUN: every `fade_dv` writes {imag, real, chan, last=(chan==0)} into the FIFO and increments the dv counter.
  - RUN, when the counter reaches N: `frame_count`++, then go to WAIT, or IDLE if `enable`=0.
  - RUN, on a tick: set `err_overrun`; the tick is skipped and `t` still increments.
  - RUN, when the watchdog (2*M*N+64 cycles since `fade_start`) expires: set `err_timeout`, go to WAIT.
- `fade_dv` outside RUN is discarded. It cannot overflow the FIFO, because space was checked at start.
- `enable` deasserted during RUN: the frame completes, then no new starts.
- `err_clear` in the same cycle as an error set: the set wins.

## Timing
- Reset values: `fade_start`=0, `fade_t_index`=0, `m_tvalid`=0, `m_tdata`=0, `m_tuser`=0, `m_tlast`=0, `busy`=0, all `err_*`=0, `frame_count`=0, `t`=0, timer=0, FSM=IDLE, FIFO empty.
- `fade_start` and `fade_t_index` are registered and update in the same cycle. `fade_t_index` holds until the next start.
- The first tick occurs eff_period cycles after `enable` rises while in WAIT.
- FIFO write occurs on the cycle after `fade_dv`. The word is visible on `m_*` one cycle later (first-word fall-through, 2-cycle dv-to-`m_tvalid` latency).
- Output handshake: a word transfers when `m_tvalid`&&`m_tready`. `m_*` are stable while `m_tvalid`=1 and `m_tready`=0.
- `busy` is high in the cycle after `fade_start` and low in the cycle after the N-th dv.

## Structure
- Package `fade_sched_pack` holds:
  - the FSM state enum {IDLE, WAIT, RUN};
  - the constants MIN_PERIOD=M*N+16 and WDOG=2*M*N+64;
  - a packed struct for the FIFO word {imag, real, chan, last}.
- One sub-module, `fade_fifo`: synchronous FWFT FIFO with async active-low reset and a `free_count` output.

## Test plan
- `period`=300, `enable`=1, fader model returns chan 31..0: `fade_start` every 300 cycles; `fade_t_index` 0,1,2…; 32 words per frame, `m_tlast` only on chan 0; `frame_count` increments.
- `period`=100: eff_period=272; start spacing is exactly 272.
- Hold `m_tready`=0 for three ticks: frames 0–1 are buffered (64 words), third tick sets `err_drop` with no start, and `t` still advances to 3.
- Fader model stalls after 10 dv: `err_timeout` at 576 cycles after start, FSM returns to WAIT, and the next tick starts normally.
- `load_t` with `t_init`=2^25−1, then two ticks: `fade_t_index`=33554431, then 0.
- Assert `reset_n`=0 mid-RUN: all outputs return to reset values asynchronously, the FIFO is empty, and no `fade_start` occurs until `enable` plus eff_period cycles.
